// File: rtl/crc_stream_pkg.sv
// crc_stream_pkg: FSM state type and word-wide CRC update helpers.
// Build option CRC_REFLECT_EN selects LSB-first (reflected) updating.
package crc_stream_pkg;

    typedef enum logic [1:0] {IDLE, DATA, CHECK, RESULT} state_t;

    localparam int MAX_W = 64;

    function automatic logic [MAX_W-1:0] reflect_bits(input logic [MAX_W-1:0] v, input int w);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < w; i++) r[i] = v[w-1-i];
        return r;
    endfunction

    // Widths are passed at elaboration time so one helper serves every engine instance.
    function automatic logic [MAX_W-1:0] crc_step(input logic [MAX_W-1:0] crc,
                                                 input logic [MAX_W-1:0] word,
                                                 input logic [MAX_W-1:0] poly,
                                                 input int dw, input int cw);
        logic [MAX_W-1:0] c, m;
        logic fb;
        m = (cw >= MAX_W) ? '1 : ((MAX_W'(1) << cw) - MAX_W'(1));
        c = crc & m;
`ifdef CRC_REFLECT_EN
        for (int i = 0; i < dw; i++) begin
            fb = c[0] ^ word[i];
            c = (c >> 1) ^ (fb ? reflect_bits(poly, cw) : '0);
        end
`else
        for (int i = dw - 1; i >= 0; i--) begin
            fb = c[cw-1] ^ word[i];
            c = ((c << 1) & m) ^ (fb ? (poly & m) : '0);
        end
`endif
        return c & m;
    endfunction

endpackage

// File: rtl/crc_stream_checker_engine.sv
// crc_stream_engine: combinational one-word CRC update (all DATA_W bit steps unrolled).
module crc_stream_engine
    import crc_stream_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CRC_W = 8,
    parameter logic [CRC_W-1:0] POLY = 8'h07
) (
    input  logic [CRC_W-1:0]  crc_in,
    input  logic [DATA_W-1:0] word,
    output logic [CRC_W-1:0]  crc_out
);

    assign crc_out = CRC_W'(crc_step(MAX_W'(crc_in), MAX_W'(word), MAX_W'(POLY), DATA_W, CRC_W));

endmodule

// File: rtl/crc_stream_checker.sv
// crc_stream_checker: count/data/check-word frame CRC checker with valid/ready links.
// Build option CRC_REFLECT_EN feeds data LSB first with the reflected polynomial.
module crc_stream_checker
    import crc_stream_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CRC_W = 8,
    parameter logic [CRC_W-1:0] POLY = 8'h07,
    parameter logic [CRC_W-1:0] INIT = 8'h00,
    parameter int LEN_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cnt_valid,
    output logic              cnt_ready,
    input  logic [LEN_W-1:0]  cnt_data,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic [DATA_W-1:0] din_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_match,
    output logic [CRC_W-1:0]  res_crc
);

    state_t state;
    logic [CRC_W-1:0] crc, crc_next;
    logic [LEN_W-1:0] rem;

    crc_stream_engine #(.DATA_W(DATA_W), .CRC_W(CRC_W), .POLY(POLY)) u_engine (
        .crc_in(crc),
        .word(din_data),
        .crc_out(crc_next)
    );

    // Ready/valid flags are registered alongside the state, so they change with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            crc <= INIT;
            rem <= '0;
            cnt_ready <= 1'b0;
            din_ready <= 1'b0;
            res_valid <= 1'b0;
            res_match <= 1'b0;
            res_crc <= '0;
        end else begin
            case (state)
                IDLE:
                    if (cnt_valid && cnt_ready) begin
                        crc <= INIT;
                        rem <= cnt_data;
                        cnt_ready <= 1'b0;
                        din_ready <= 1'b1;
                        state <= (cnt_data != '0) ? DATA : CHECK;
                    end else begin
                        cnt_ready <= 1'b1;
                    end
                DATA:
                    if (din_valid && din_ready) begin
                        crc <= crc_next;
                        rem <= rem - LEN_W'(1);
                        if (rem == LEN_W'(1)) state <= CHECK;
                    end
                CHECK:
                    if (din_valid && din_ready) begin
                        res_match <= (din_data[CRC_W-1:0] == crc);
                        res_crc <= crc;
                        din_ready <= 1'b0;
                        res_valid <= 1'b1;
                        state <= RESULT;
                    end
                RESULT:
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        cnt_ready <= 1'b1;
                        state <= IDLE;
                    end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crc_stream_checker.sv
// tb_crc_stream_checker: directed vector table, back-pressure and async-reset sequences, random frames.
module tb_crc_stream_checker;

`ifdef CRC_REFLECT_EN
    localparam bit REFL = 1'b1;
`else
    localparam bit REFL = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0;
    logic cnt_valid = 1'b0, din_valid = 1'b0, res_ready = 1'b0;
    logic [7:0] cnt_data = '0, din_data = '0;
    logic cnt_ready, din_ready, res_valid, res_match;
    logic [7:0] res_crc;

    int n_checks = 0, n_fail = 0;

    crc_stream_checker dut (
        .clk(clk), .rst_n(rst_n),
        .cnt_valid(cnt_valid), .cnt_ready(cnt_ready), .cnt_data(cnt_data),
        .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_match(res_match), .res_crc(res_crc)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          len;
        logic [71:0] d;
        logic [7:0]  chk;
        logic [7:0]  exp_crc;
        logic        exp_m;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for handshake", name);
    endtask

    function automatic logic [7:0] model_crc(input logic [7:0] q[$]);
        logic [7:0] c;
        logic fb;
        c = 8'h00;
        foreach (q[k]) begin
`ifdef CRC_REFLECT_EN
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ q[k][b];
                c = {1'b0, c[7:1]} ^ (fb ? 8'hE0 : 8'h00);
            end
`else
            for (int b = 7; b >= 0; b--) begin
                fb = c[7] ^ q[k][b];
                c = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
`endif
        end
        return c;
    endfunction

    task automatic send_cnt(input logic [7:0] v);
        bit ok;
        int cyc;
        cnt_valid = 1'b1;
        cnt_data = v;
        cyc = 0;
        forever begin
            ok = cnt_ready;
            @(negedge clk);
            cyc++;
            if (ok) break;
            if (cyc > 1000) begin
                timeout("cnt");
                break;
            end
        end
        cnt_valid = 1'b0;
    endtask

    task automatic send_din(input logic [7:0] v, output int cyc);
        bit ok;
        din_valid = 1'b1;
        din_data = v;
        cyc = 0;
        forever begin
            ok = din_ready;
            @(negedge clk);
            cyc++;
            if (ok) break;
            if (cyc > 1000) begin
                timeout("din");
                break;
            end
        end
        din_valid = 1'b0;
    endtask

    task automatic recv_res(input bit rnd, output logic [7:0] c, output logic m);
        bit ok;
        int cyc;
        cyc = 0;
        c = '0;
        m = 1'b0;
        forever begin
            res_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            ok = res_valid && res_ready;
            c = res_crc;
            m = res_match;
            @(negedge clk);
            cyc++;
            if (ok) break;
            if (cyc > 1000) begin
                timeout("res");
                break;
            end
        end
        res_ready = 1'b0;
    endtask

    task automatic run_frame(input int len, input logic [7:0] q[$], input logic [7:0] cw,
                             input bit gaps, input bit rnd,
                             output logic [7:0] c, output logic m, output int dcyc, output int ccyc);
        int n;
        send_cnt(8'(len));
        dcyc = 0;
        for (int i = 0; i < len; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            send_din(q[i], n);
            dcyc += n;
        end
        if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        send_din(cw, ccyc);
        chk("res_valid one cycle after check word", res_valid, 1);
        recv_res(rnd, c, m);
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] c, e, cw;
        logic m;
        int dc, cc, len;

        for (int i = 0; i < 9; i++) q.push_back(8'h31 + 8'(i));
        e = REFL ? model_crc(q) : 8'hF4;
        vt[0] = '{9, 72'h393837363534333231, e, e, 1'b1};
        vt[1] = '{9, 72'h393837363534333231, ~e, e, 1'b0};
        vt[2] = '{1, 72'h01, 8'h00, REFL ? 8'h91 : 8'h07, 1'b0};
        vt[3] = '{1, 72'h01, REFL ? 8'h91 : 8'h07, REFL ? 8'h91 : 8'h07, 1'b1};
        vt[4] = '{0, 72'h0, 8'h00, 8'h00, 1'b1};
        vt[5] = '{0, 72'h0, 8'h55, 8'h00, 1'b0};
        vt[6] = '{1, 72'h80, REFL ? 8'hE0 : 8'h89, REFL ? 8'hE0 : 8'h89, 1'b1};
        vt[7] = '{2, 72'h0001, REFL ? 8'h6D : 8'h15, REFL ? 8'h6D : 8'h15, 1'b1};

        #1;
        chk("reset cnt_ready", cnt_ready, 0);
        chk("reset din_ready", din_ready, 0);
        chk("reset res_valid", res_valid, 0);
        chk("reset res_match", res_match, 0);
        chk("reset res_crc", res_crc, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle cnt_ready", cnt_ready, 1);
        chk("idle din_ready", din_ready, 0);

        foreach (vt[t]) begin
            q.delete();
            for (int i = 0; i < vt[t].len; i++) q.push_back(vt[t].d[8*i +: 8]);
            run_frame(vt[t].len, q, vt[t].chk, 1'b0, 1'b0, c, m, dc, cc);
            chk($sformatf("vec%0d res_crc", t), c, vt[t].exp_crc);
            chk($sformatf("vec%0d res_match", t), m, vt[t].exp_m);
            chk($sformatf("vec%0d data cycles", t), dc, vt[t].len);
            chk($sformatf("vec%0d check cycles", t), cc, 1);
        end

        // Result stalled while a new count and a data word are both pending.
        send_cnt(8'd1);
        send_din(8'h01, dc);
        send_din(REFL ? 8'h91 : 8'h07, dc);
        cnt_valid = 1'b1;
        cnt_data = 8'd3;
        din_valid = 1'b1;
        din_data = 8'hAA;
        res_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("stall res_valid", res_valid, 1);
            chk("stall res_crc", res_crc, REFL ? 8'h91 : 8'h07);
            chk("stall res_match", res_match, 1);
            chk("stall cnt_ready", cnt_ready, 0);
            chk("stall din_ready", din_ready, 0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("post-handshake res_valid", res_valid, 0);
        chk("post-handshake cnt_ready", cnt_ready, 1);
        chk("post-handshake din_ready", din_ready, 0);
        cnt_valid = 1'b0;
        din_valid = 1'b0;

        // Asynchronous reset after 4 of 9 data words.
        send_cnt(8'd9);
        for (int i = 0; i < 4; i++) send_din(8'h31 + 8'(i), dc);
        din_valid = 1'b1;
        din_data = 8'h35;
        chk("mid-frame din_ready", din_ready, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset cnt_ready", cnt_ready, 0);
        chk("async reset din_ready", din_ready, 0);
        chk("async reset res_valid", res_valid, 0);
        chk("async reset res_match", res_match, 0);
        chk("async reset res_crc", res_crc, 0);
        @(negedge clk);
        din_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        for (int i = 0; i < 9; i++) q.push_back(8'h31 + 8'(i));
        run_frame(9, q, vt[0].chk, 1'b0, 1'b0, c, m, dc, cc);
        chk("after reset res_crc", c, vt[0].exp_crc);
        chk("after reset res_match", m, 1);

        for (int f = 0; f < 100; f++) begin
            len = $urandom_range(0, 255);
            q.delete();
            for (int i = 0; i < len; i++) q.push_back(8'($urandom));
            e = model_crc(q);
            cw = ($urandom_range(0, 1) == 1) ? e : 8'($urandom);
            run_frame(len, q, cw, 1'b1, 1'b1, c, m, dc, cc);
            chk($sformatf("rand%0d len%0d res_crc", f, len), c, e);
            chk($sformatf("rand%0d len%0d res_match", f, len), m, cw == e);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
